// File: rtl/func_sched.sv
// rtl/func_sched.sv - round-robin scheduler sharing one accumulate engine among NREQ requesters
module func_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_base_ptr,
  input  logic [32*NREQ-1:0]   req_size,
  output logic [NREQ-1:0]      req_done,
  output logic [31:0]          req_result,
  output logic                 req_error,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 eng_start,
  output logic [31:0]          eng_base_ptr,
  output logic [31:0]          eng_size,
  input  logic                 eng_done,
  input  logic [31:0]          eng_result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [31:0] WD_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic        WD_ON   = (TIMEOUT != 0);

  logic [1:0]  state;
  logic [2:0]  last_grant;
  logic [31:0] wd_cnt;

  logic        pick_valid;
  logic [2:0]  pick_id;
  int          pick_idx;
  logic [31:0] pick_base;
  logic [31:0] pick_size;
  logic        wd_hit;

  // Search upward from the requester after the last grant, wrapping, so the
  // requester that just finished has the lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 3'd0;
    pick_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pick_idx = (int'(last_grant) + k) % NREQ;
      if (!pick_valid && req_valid[pick_idx]) begin
        pick_valid = 1'b1;
        pick_id    = 3'(pick_idx);
      end
    end
  end

  assign pick_base = req_base_ptr[int'(pick_id)*32 +: 32];
  assign pick_size = req_size[int'(pick_id)*32 +: 32];
  assign wd_hit    = WD_ON && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      last_grant   <= 3'(NREQ - 1);
      wd_cnt       <= 32'd0;
      eng_start    <= 1'b0;
      eng_base_ptr <= 32'd0;
      eng_size     <= 32'd0;
      req_done     <= '0;
      req_result   <= 32'd0;
      req_error    <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= 3'd0;
    end else begin
      eng_start <= 1'b0;
      req_done  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant_id     <= pick_id;
            eng_base_ptr <= pick_base;
            eng_size     <= pick_size;
            busy         <= 1'b1;
            if (pick_size == 32'd0) begin
              // Empty job: answer directly without waking the engine.
              req_result <= 32'd0;
              req_error  <= 1'b0;
              req_done   <= NREQ'(1) << pick_id;
              state      <= S_RESP;
            end else begin
              eng_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wd_cnt <= 32'd0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (eng_done) begin
            req_result <= eng_result;
            req_error  <= 1'b0;
            req_done   <= NREQ'(1) << grant_id;
            state      <= S_RESP;
          end else if (wd_hit) begin
            req_result <= 32'd0;
            req_error  <= 1'b1;
            req_done   <= NREQ'(1) << grant_id;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_sched.sv
// tb/tb_func_sched.sv - directed-vector bench for func_sched with a hand-driven engine
module tb_func_sched;

  localparam int NREQ = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [63:0]      req_base_ptr;
  logic [63:0]      req_size;
  logic [NREQ-1:0]  req_done;
  logic [31:0]      req_result;
  logic             req_error;
  logic             busy;
  logic [2:0]       grant_id;
  logic             eng_start;
  logic [31:0]      eng_base_ptr;
  logic [31:0]      eng_size;
  logic             eng_done;
  logic [31:0]      eng_result;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  func_sched #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_base_ptr (req_base_ptr),
    .req_size     (req_size),
    .req_done     (req_done),
    .req_result   (req_result),
    .req_error    (req_error),
    .busy         (busy),
    .grant_id     (grant_id),
    .eng_start    (eng_start),
    .eng_base_ptr (eng_base_ptr),
    .eng_size     (eng_size),
    .eng_done     (eng_done),
    .eng_result   (eng_result)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!eng_start && n < 20) begin
      step();
      n++;
    end
    check_val("eng_start_seen", 32'(eng_start), 32'd1);
  endtask

  initial begin
    int n;
    int exp_id;
    logic [NREQ-1:0] seen;

    reset        = 1'b0;
    req_valid    = '0;
    req_base_ptr = '0;
    req_size     = '0;
    eng_done     = 1'b0;
    eng_result   = 32'd0;

    // Reset state
    step();
    step();
    check_val("rst_eng_start", 32'(eng_start), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_req_done", 32'(req_done), 32'd0);
    check_val("rst_grant_id", 32'(grant_id), 32'd0);
    check_val("rst_eng_base", eng_base_ptr, 32'd0);
    check_val("rst_req_result", req_result, 32'd0);
    reset = 1'b1;
    step();

    // Single job on requester 0
    req_base_ptr[31:0] = 32'h1000;
    req_size[31:0]     = 32'd8;
    req_valid          = 2'b01;
    step();
    check_val("single_eng_start", 32'(eng_start), 32'd1);
    check_val("single_eng_base", eng_base_ptr, 32'h1000);
    check_val("single_eng_size", eng_size, 32'd8);
    check_val("single_busy", 32'(busy), 32'd1);
    step();
    check_val("single_start_pulse", 32'(eng_start), 32'd0);
    eng_done   = 1'b1;
    eng_result = 32'h40A00000;
    step();
    eng_done  = 1'b0;
    req_valid = 2'b00;
    check_val("single_req_done", 32'(req_done), 32'd1);
    check_val("single_result", req_result, 32'h40A00000);
    check_val("single_error", 32'(req_error), 32'd0);
    step();
    check_val("single_done_pulse", 32'(req_done), 32'd0);

    // Zero-size job on requester 1
    req_base_ptr[63:32] = 32'h2000;
    req_size[63:32]     = 32'd0;
    req_valid           = 2'b10;
    step();
    check_val("zero_req_done", 32'(req_done), 32'd2);
    check_val("zero_result", req_result, 32'd0);
    check_val("zero_no_start_a", 32'(eng_start), 32'd0);
    req_valid = 2'b00;
    step();
    check_val("zero_no_start_b", 32'(eng_start), 32'd0);

    // Contention: alternate grants, 4 jobs each
    req_base_ptr = {32'h4000, 32'h3000};
    req_size     = {32'd12, 32'd4};
    req_valid    = 2'b11;
    for (int j = 0; j < 8; j++) begin
      exp_id = j % 2;
      wait_start();
      check_val("cont_grant", 32'(grant_id), 32'(exp_id));
      check_val("cont_base", eng_base_ptr, (exp_id == 1) ? 32'h4000 : 32'h3000);
      check_val("cont_size", eng_size, (exp_id == 1) ? 32'd12 : 32'd4);
      step();
      eng_done   = 1'b1;
      eng_result = 32'h100 + 32'(j);
      step();
      eng_done = 1'b0;
      check_val("cont_req_done", 32'(req_done), (exp_id == 1) ? 32'd2 : 32'd1);
      check_val("cont_result", req_result, 32'h100 + 32'(j));
      req_valid[exp_id] = 1'b0;
      step();
      step();
      if (j < 6) req_valid[exp_id] = 1'b1;
    end

    // Watchdog: engine stays silent
    req_base_ptr[31:0] = 32'h5000;
    req_size[31:0]     = 32'd5;
    req_valid          = 2'b01;
    wait_start();
    n = 0;
    while (req_done == '0 && n < 40) begin
      step();
      n++;
    end
    check_val("wd_latency", 32'(n), 32'd17);
    check_val("wd_req_done", 32'(req_done), 32'd1);
    check_val("wd_error", 32'(req_error), 32'd1);
    check_val("wd_result", req_result, 32'd0);
    req_valid = 2'b00;
    repeat (5) step();
    eng_done   = 1'b1;
    eng_result = 32'hDEADBEEF;
    step();
    eng_done = 1'b0;
    seen = req_done;
    repeat (5) begin
      step();
      seen = seen | req_done;
    end
    check_val("wd_late_done_ignored", 32'(seen), 32'd0);
    check_val("wd_idle_busy", 32'(busy), 32'd0);

    // Done arriving in the final WAIT cycle beats the timeout
    req_base_ptr[63:32] = 32'h6000;
    req_size[63:32]     = 32'd3;
    req_valid           = 2'b10;
    wait_start();
    check_val("coll_grant", 32'(grant_id), 32'd1);
    repeat (16) step();
    check_val("coll_no_early", 32'(req_done), 32'd0);
    eng_done   = 1'b1;
    eng_result = 32'hCAFEF00D;
    step();
    eng_done = 1'b0;
    check_val("coll_req_done", 32'(req_done), 32'd2);
    check_val("coll_error", 32'(req_error), 32'd0);
    check_val("coll_result", req_result, 32'hCAFEF00D);
    req_valid = 2'b00;
    step();

    // Reset while the engine is busy
    req_valid = 2'b10;
    wait_start();
    step();
    step();
    #1 reset = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_eng_base", eng_base_ptr, 32'd0);
    check_val("mid_rst_eng_size", eng_size, 32'd0);
    check_val("mid_rst_grant", 32'(grant_id), 32'd0);
    check_val("mid_rst_result", req_result, 32'd0);
    req_valid = 2'b00;
    step();
    step();
    reset      = 1'b1;
    eng_done   = 1'b1;
    eng_result = 32'h55555555;
    step();
    eng_done = 1'b0;
    seen = req_done;
    step();
    seen = seen | req_done;
    check_val("mid_rst_stale_done", 32'(seen), 32'd0);
    req_base_ptr[31:0] = 32'h7000;
    req_size[31:0]     = 32'd2;
    req_valid          = 2'b11;
    wait_start();
    check_val("post_rst_grant", 32'(grant_id), 32'd0);
    check_val("post_rst_base", eng_base_ptr, 32'h7000);
    step();
    eng_done   = 1'b1;
    eng_result = 32'h1234;
    step();
    eng_done = 1'b0;
    check_val("post_rst_req_done", 32'(req_done), 32'd1);
    check_val("post_rst_result", req_result, 32'h1234);
    req_valid = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
